vpaddle: RTL and testbench
==========================

# vpaddle

Vertical paddle generator for one player. It converts a digital paddle position into a 16-line paddle stripe on screen. It drives the paddle video and the 3-bit paddle segment code (B, C, D) that the vertical ball counter latches on HIT to choose vertical ball speed. One instance is built per player: the player-1 instance feeds B1/C1/D1 and the player-2 instance feeds B2/C2/D2.

## Interface
Parameters:
- POS_W, 8: width of the position input and the line counter.
- POS_MAX, 8'd231: highest legal paddle start line. Used only when clamping is compiled in.

Ports:
- CLK_DRV  in  1  system clock. All state changes on its rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- HSYNC_N  in  1  horizontal sync, active-low. One scan line per rising edge.
- VBLANK  in  1  vertical blank, active-high.
- PADH  in  1  horizontal paddle window for this player.
- POS  in  POS_W  requested paddle start line, counted in lines after VBLANK falls.
- ATTRACT  in  1  attract mode. When high, paddle video is suppressed.
- PAD  out  1  paddle video.
- PAD_N  out  1  complement of PAD.
- SEG_B, SEG_C, SEG_D  out  1 each  paddle segment code: bits 1, 2 and 3 of the stripe line counter.
- DRAWING  out  1  high while the stripe lines are active.

## Operation
- HSYNC_N edge detection: a registered copy of HSYNC_N is kept. `hs_rise = HSYNC_N & ~hsync_q`.
- Position capture: on the rising edge of VBLANK (detected by a registered copy of VBLANK), POS is latched into `pos_q`. POS changes at any other time have no effect until the next frame.
- FSM states and transitions:
  - IDLE → WAIT when VBLANK falls. Line counter loads `pos_q`.
  - WAIT: on each `hs_rise`, the line counter decrements. On `hs_rise` with the counter at 0, go to DRAW and clear the stripe counter.
  - DRAW: on each `hs_rise`, the stripe counter increments. On `hs_rise` with the stripe counter at 15, go to DONE.
  - DONE → IDLE when VBLANK rises.
  - Any state → IDLE when VBLANK rises, whatever the current state. No wrap into the next frame.
- If `pos_q == 0`, the stripe starts on the first line after VBLANK falls.
- Outputs:
  - DRAWING = (state == DRAW).
  - PAD = DRAWING & PADH & ~ATTRACT. PAD_N = ~PAD.
  - SEG_B/C/D = stripe counter bits 1, 2 and 3 while DRAWING. They hold their last value otherwise, so the ball logic always sees a stable code.
- Arithmetic: the line counter is POS_W bits and the stripe counter is 4 bits. Neither wraps: the FSM leaves each state before a counter can wrap.
- Simultaneous VBLANK rise and `hs_rise`: VBLANK wins. The FSM goes to IDLE and the counter update is discarded.
- Reset mid-frame: the FSM returns to IDLE and waits for the next VBLANK fall before drawing.

## Timing
- Reset values:
  - state = IDLE; pos_q = 0; line counter = 0; stripe counter = 0.
  - PAD = 0, PAD_N = 1, DRAWING = 0, SEG_B/C/D = 0.
  - hsync_q = 1, vblank_q = 0.
- All outputs are registered or decoded directly from registers.
- PAD follows PADH and ATTRACT combinationally, with no added latency.
- DRAWING rises 1 CLK_DRV cycle after the HSYNC_N rising edge that ends line `pos_q`, measured from the VBLANK fall.
- The stripe lasts exactly 16 `hs_rise` intervals.
- SEG outputs change on the same clock edge as the stripe counter.

## Configuration
- Macro: VPADDLE_CLAMP_EN.
- Defined: `pos_q` captures min(POS, POS_MAX), so the stripe always finishes before the bottom of the playfield.
- Undefined: POS is captured raw. If VBLANK arrives before the stripe completes, the stripe is truncated by the VBLANK override.

## Structure
- Shared package pong_pkg holds:
  - the `vpaddle_state_t` enum (IDLE, WAIT, DRAW, DONE);
  - localparam PAD_LINES = 16;
  - the default POS_MAX.
- One sub-module, edge_det: a registered rising/falling edge detector with synchronous active-low reset. It is instantiated twice, once for HSYNC_N and once for VBLANK.

## Test plan
- Reset held low for 3 cycles in mid-DRAW → PAD = 0, SEG = 000, DRAWING = 0. No stripe appears until after the next VBLANK fall.
- POS = 20, PADH = 1, ATTRACT = 0 → DRAWING is high for lines 21–36 after the VBLANK fall (16 lines). SEG_D/C/B step 000, 000, 001, 001, … 111, changing every 2 lines.
- POS = 0 → stripe covers lines 1–16. POS changed to 100 mid-frame → no effect until the frame after the next VBLANK rise.
- ATTRACT = 1 with POS = 50 → PAD stays 0 throughout, while DRAWING and SEG still sequence normally.
- POS = 250 with VPADDLE_CLAMP_EN defined → stripe starts at line 232 and completes. Without the macro → stripe starts at line 251 and is cut to IDLE when VBLANK rises. PAD and DRAWING = 0 at that edge.
- VBLANK rise on the same cycle as `hs_rise` during DRAW → state is IDLE the next cycle and the stripe counter does not advance.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong video blocks: paddle FSM states and paddle geometry.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } vpaddle_state_t;

    localparam int         PAD_LINES       = 16;
    localparam logic [7:0] POS_MAX_DEFAULT = 8'd231;

endpackage

// File: rtl/edge_det.sv
// Registered edge detector: one flop of history, combinational rise/fall strobes.
module edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    always_ff @(posedge clk) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= d;
    end

    assign rise = d & ~q;
    assign fall = ~d & q;

endmodule

// File: rtl/vpaddle.sv
// Vertical paddle generator: 16-line stripe starting pos_q lines after VBLANK falls.
// Optional VPADDLE_CLAMP_EN limits the captured start line to POS_MAX.
module vpaddle
    import pong_pkg::*;
#(
    parameter int               POS_W   = 8,
    parameter logic [POS_W-1:0] POS_MAX = POS_W'(POS_MAX_DEFAULT)
) (
    input  logic             CLK_DRV,
    input  logic             RST_N,
    input  logic             HSYNC_N,
    input  logic             VBLANK,
    input  logic             PADH,
    input  logic [POS_W-1:0] POS,
    input  logic             ATTRACT,
    output logic             PAD,
    output logic             PAD_N,
    output logic             SEG_B,
    output logic             SEG_C,
    output logic             SEG_D,
    output logic             DRAWING
);

`ifdef VPADDLE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    vpaddle_state_t   state;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] line_cnt;
    logic [3:0]       stripe_cnt;
    logic [POS_W-1:0] pos_cap;
    logic             hs_rise, hs_fall_unused;
    logic             vb_rise, vb_fall;

    edge_det #(.RST_VAL(1'b1)) u_hs_edge (
        .clk  (CLK_DRV),
        .rst_n(RST_N),
        .d    (HSYNC_N),
        .rise (hs_rise),
        .fall (hs_fall_unused)
    );

    edge_det #(.RST_VAL(1'b0)) u_vb_edge (
        .clk  (CLK_DRV),
        .rst_n(RST_N),
        .d    (VBLANK),
        .rise (vb_rise),
        .fall (vb_fall)
    );

    assign pos_cap = (CLAMP && (POS > POS_MAX)) ? POS_MAX : POS;

    // VBLANK rise overrides everything, including a coincident line edge.
    always_ff @(posedge CLK_DRV) begin
        if (!RST_N) begin
            state      <= IDLE;
            pos_q      <= '0;
            line_cnt   <= '0;
            stripe_cnt <= '0;
        end else if (vb_rise) begin
            state <= IDLE;
            pos_q <= pos_cap;
        end else begin
            case (state)
                IDLE: if (vb_fall) begin
                    state    <= WAIT;
                    line_cnt <= pos_q;
                end
                WAIT: if (hs_rise) begin
                    if (line_cnt == '0) begin
                        state      <= DRAW;
                        stripe_cnt <= '0;
                    end else begin
                        line_cnt <= line_cnt - POS_W'(1);
                    end
                end
                DRAW: if (hs_rise) begin
                    if (stripe_cnt == 4'(PAD_LINES - 1)) state <= DONE;
                    else                                 stripe_cnt <= stripe_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // The stripe counter only moves in DRAW, so its bits double as the held segment code.
    assign DRAWING = (state == DRAW);
    assign PAD     = DRAWING & PADH & ~ATTRACT;
    assign PAD_N   = ~PAD;
    assign SEG_B   = stripe_cnt[1];
    assign SEG_C   = stripe_cnt[2];
    assign SEG_D   = stripe_cnt[3];

endmodule

// File: tb/tb_vpaddle.sv
// Self-checking bench for vpaddle: frame-level model of which lines carry the stripe.
module tb_vpaddle;

    logic       CLK_DRV = 1'b0;
    logic       RST_N, HSYNC_N, VBLANK, PADH, ATTRACT;
    logic [7:0] POS;
    logic       PAD, PAD_N, SEG_B, SEG_C, SEG_D, DRAWING;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_pos = 0;
    logic [2:0] m_seg = 3'd0;
    logic       m_draw_prev = 1'b0;

    vpaddle dut (
        .CLK_DRV(CLK_DRV), .RST_N(RST_N), .HSYNC_N(HSYNC_N), .VBLANK(VBLANK),
        .PADH(PADH), .POS(POS), .ATTRACT(ATTRACT), .PAD(PAD), .PAD_N(PAD_N),
        .SEG_B(SEG_B), .SEG_C(SEG_C), .SEG_D(SEG_D), .DRAWING(DRAWING)
    );

    always #5 CLK_DRV = ~CLK_DRV;

    function automatic int clampf(input int p);
`ifdef VPADDLE_CLAMP_EN
        return (p > 231) ? 231 : p;
`else
        return p;
`endif
    endfunction

    // One scan line k after the VBLANK fall; line k is drawn when p+1 <= k <= p+16.
    task automatic do_line(input int k, input int p);
        logic ed, ep;
        @(posedge CLK_DRV); #1;
        HSYNC_N = 1'b0;
        PADH    = 1'($urandom_range(0, 1));
        @(posedge CLK_DRV); #1;
        HSYNC_N = 1'b1;
        @(negedge CLK_DRV);
        n_cmp++;
        if (DRAWING !== m_draw_prev) begin
            n_bad++;
            $display("FAIL pre_edge_drawing line %0d: got %b want %b", k, DRAWING, m_draw_prev);
        end
        ed = (k >= p + 1) && (k <= p + 16);
        if (ed) m_seg = 3'((k - p - 1) >> 1);
        @(posedge CLK_DRV);
        @(negedge CLK_DRV);
        n_cmp++;
        if (DRAWING !== ed) begin
            n_bad++;
            $display("FAIL drawing line %0d pos %0d: got %b want %b", k, p, DRAWING, ed);
        end
        n_cmp++;
        if ({SEG_D, SEG_C, SEG_B} !== m_seg) begin
            n_bad++;
            $display("FAIL seg line %0d pos %0d: got %b want %b", k, p, {SEG_D, SEG_C, SEG_B}, m_seg);
        end
        ep = ed & PADH & ~ATTRACT;
        n_cmp++;
        if (PAD !== ep || PAD_N !== ~ep) begin
            n_bad++;
            $display("FAIL pad line %0d: got PAD=%b PAD_N=%b want PAD=%b", k, PAD, PAD_N, ep);
        end
        PADH = ~PADH;
        #1;
        ep = ed & PADH & ~ATTRACT;
        n_cmp++;
        if (PAD !== ep) begin
            n_bad++;
            $display("FAIL pad_comb line %0d: got %b want %b", k, PAD, ep);
        end
        m_draw_prev = ed;
    endtask

    task automatic start_frame();
        @(posedge CLK_DRV); #1;
        VBLANK = 1'b0;
        repeat (2) @(posedge CLK_DRV);
    endtask

    task automatic end_frame(input bit conflict);
        @(posedge CLK_DRV); #1;
        if (conflict) begin
            HSYNC_N = 1'b0;
            @(posedge CLK_DRV); #1;
            HSYNC_N = 1'b1;
        end
        VBLANK = 1'b1;
        m_pos  = clampf(int'(POS));
        @(posedge CLK_DRV);
        @(negedge CLK_DRV);
        n_cmp++;
        if (DRAWING !== 1'b0 || PAD !== 1'b0) begin
            n_bad++;
            $display("FAIL vblank_cut: got DRAWING=%b PAD=%b want 0 0", DRAWING, PAD);
        end
        n_cmp++;
        if ({SEG_D, SEG_C, SEG_B} !== m_seg) begin
            n_bad++;
            $display("FAIL seg_hold_vblank: got %b want %b", {SEG_D, SEG_C, SEG_B}, m_seg);
        end
        m_draw_prev = 1'b0;
        repeat (4) @(posedge CLK_DRV);
    endtask

    task automatic run_frame(input int lines);
        start_frame();
        for (int k = 1; k <= lines; k++) do_line(k, m_pos);
        end_frame(1'b0);
    endtask

    task automatic prime(input int p);
        POS = 8'(p);
        start_frame();
        end_frame(1'b0);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; VBLANK = 1'b1; HSYNC_N = 1'b1; PADH = 1'b1; ATTRACT = 1'b0; POS = 8'd20;
        repeat (3) @(posedge CLK_DRV);
        @(negedge CLK_DRV);
        n_cmp++;
        if (PAD !== 1'b0 || PAD_N !== 1'b1 || DRAWING !== 1'b0 || {SEG_D, SEG_C, SEG_B} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_outputs: got PAD=%b PAD_N=%b DRAWING=%b SEG=%b want 0 1 0 000",
                     PAD, PAD_N, DRAWING, {SEG_D, SEG_C, SEG_B});
        end
        @(posedge CLK_DRV); #1;
        RST_N = 1'b1;
        m_pos = clampf(20);
        repeat (3) @(posedge CLK_DRV);
    endtask

    task automatic test_basic();
        start_frame();
        for (int k = 1; k <= 45; k++) begin
            if (k == 10) POS = 8'd0;
            do_line(k, m_pos);
        end
        end_frame(1'b0);
    endtask

    task automatic test_pos_zero();
        start_frame();
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) POS = 8'd100;
            do_line(k, m_pos);
        end
        end_frame(1'b0);
        run_frame(130);
    endtask

    task automatic test_attract();
        prime(50);
        ATTRACT = 1'b1;
        run_frame(80);
        ATTRACT = 1'b0;
    endtask

    task automatic test_big_pos();
        prime(250);
        run_frame(260);
    endtask

    task automatic test_conflict();
        prime(10);
        start_frame();
        for (int k = 1; k <= 16; k++) do_line(k, m_pos);
        end_frame(1'b1);
    endtask

    task automatic test_reset_mid_draw();
        prime(30);
        start_frame();
        for (int k = 1; k <= 36; k++) do_line(k, m_pos);
        @(posedge CLK_DRV); #1;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK_DRV);
        @(negedge CLK_DRV);
        n_cmp++;
        if (PAD !== 1'b0 || DRAWING !== 1'b0 || {SEG_D, SEG_C, SEG_B} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_mid_draw: got PAD=%b DRAWING=%b SEG=%b want 0 0 000",
                     PAD, DRAWING, {SEG_D, SEG_C, SEG_B});
        end
        @(posedge CLK_DRV); #1;
        RST_N = 1'b1;
        m_seg = 3'd0;
        m_draw_prev = 1'b0;
        for (int k = 37; k <= 60; k++) do_line(k, 1000);
        end_frame(1'b0);
        run_frame(50);
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            prime(int'($urandom_range(0, 255)));
            ATTRACT = 1'($urandom_range(0, 1));
            run_frame(int'($urandom_range(20, 270)));
        end
        ATTRACT = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pos_zero();
        test_attract();
        test_big_pos();
        test_conflict();
        test_reset_mid_draw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
